// File: rtl/seg7_to_bcd.sv
// seg7_to_bcd
//   Decodes a pair of active-low seven-segment patterns (tens, ones) into a
//   binary value 0..15. It uses a ready/valid handshake on both sides and
//   keeps a saturating count of error results that have been delivered.
//
//   Pipeline: IDLE -> CAPTURE -> DECODE -> HOLD -> IDLE.
//     Transfer at edge N. Each digit is classified at edge N+1. The result
//     is registered with out_valid at edge N+2. It is then held until the
//     consumer accepts it.
//
//   Ports
//     clk        in   sole clock, rising edge
//     rst_n      in   asynchronous active-low reset
//     seg_ones   in   [6:0] ones digit, active-low, bit6=g .. bit0=a
//     seg_tens   in   [6:0] tens digit, active-low, same bit order
//     in_valid   in   input pair presented
//     in_ready   out  block can accept (IDLE only)
//     bcd        out  [3:0] decoded value
//     err        out  pair not decodable or value > 15
//     out_valid  out  bcd/err valid
//     out_ready  in   consumer accepts
//     err_cnt    out  [7:0] saturating count of delivered err results
//
//   Configuration
//     SEG_ALT5_EN  when defined, ones pattern 1001001 is also accepted as 5.
module seg7_to_bcd (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_ones,
  input  logic [6:0] seg_tens,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] bcd,
  output logic       err,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DECODE  = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [6:0] ones_q, ones_d;
  logic [6:0] tens_q, tens_d;
  logic [3:0] ones_val_q, ones_val_d;
  logic       ones_ok_q, ones_ok_d;
  logic       tens_one_q, tens_one_d;
  logic       tens_ok_q, tens_ok_d;
  logic [3:0] bcd_q, bcd_d;
  logic       err_q, err_d;
  logic       out_valid_q, out_valid_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  // Classification of the captured ones pattern.
  logic [3:0] ones_dec;
  logic       ones_dec_ok;

  always_comb begin
    ones_dec    = 4'd0;
    ones_dec_ok = 1'b1;
    case (ones_q)
      7'b1000000: ones_dec = 4'd0;
      7'b1111001: ones_dec = 4'd1;
      7'b0100100: ones_dec = 4'd2;
      7'b0110000: ones_dec = 4'd3;
      7'b0011001: ones_dec = 4'd4;
      7'b0010010: ones_dec = 4'd5;
`ifdef SEG_ALT5_EN
      7'b1001001: ones_dec = 4'd5;
`endif
      7'b0000010: ones_dec = 4'd6;
      7'b1111000: ones_dec = 4'd7;
      7'b0000000: ones_dec = 4'd8;
      7'b0011000: ones_dec = 4'd9;
      default:    ones_dec_ok = 1'b0;
    endcase
  end

  // The sum is 5 bits wide. The tens digit is 0 or 1, so the largest
  // value is 19. Any value above 15 is an error.
  logic [4:0] value;
  assign value = (tens_one_q ? 5'd10 : 5'd0) + {1'b0, ones_val_q};

  always_comb begin
    state_d     = state_q;
    ones_d      = ones_q;
    tens_d      = tens_q;
    ones_val_d  = ones_val_q;
    ones_ok_d   = ones_ok_q;
    tens_one_d  = tens_one_q;
    tens_ok_d   = tens_ok_q;
    bcd_d       = bcd_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    err_cnt_d   = err_cnt_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          ones_d  = seg_ones;
          tens_d  = seg_tens;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        ones_val_d = ones_dec;
        ones_ok_d  = ones_dec_ok;
        // An all-segments-lit tens pattern encodes tens digit 0.
        tens_one_d = (tens_q == 7'b1111001);
        tens_ok_d  = (tens_q == 7'b1111001) || (tens_q == 7'b0000000);
        state_d    = DECODE;
      end
      DECODE: begin
        if (!ones_ok_q || !tens_ok_q || (value > 5'd15)) begin
          bcd_d = 4'd0;
          err_d = 1'b1;
        end else begin
          bcd_d = value[3:0];
          err_d = 1'b0;
        end
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (err_q && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ones_q      <= 7'h7F;
      tens_q      <= 7'h7F;
      ones_val_q  <= 4'd0;
      ones_ok_q   <= 1'b0;
      tens_one_q  <= 1'b0;
      tens_ok_q   <= 1'b0;
      bcd_q       <= 4'd0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      err_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      ones_q      <= ones_d;
      tens_q      <= tens_d;
      ones_val_q  <= ones_val_d;
      ones_ok_q   <= ones_ok_d;
      tens_one_q  <= tens_one_d;
      tens_ok_q   <= tens_ok_d;
      bcd_q       <= bcd_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign bcd       = bcd_q;
  assign err       = err_q;
  assign out_valid = out_valid_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_seg7_to_bcd.sv
// Self-checking bench for seg7_to_bcd. Expected results are pushed to a
// scoreboard queue when a pair is driven. They are popped when the DUT
// presents its output.
module tb_seg7_to_bcd;

  logic       clk;
  logic       rst_n;
  logic [6:0] seg_ones;
  logic [6:0] seg_tens;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] bcd;
  logic       err;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] err_cnt;

  seg7_to_bcd dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg_ones  (seg_ones),
    .seg_tens  (seg_tens),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bcd       (bcd),
    .err       (err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] bcd;
    logic       err;
  } sb_t;

  sb_t sb[$];
  int  compared   = 0;
  int  mismatched = 0;
  int  exp_cnt    = 0;

  localparam logic [6:0] T0 = 7'b0000000;
  localparam logic [6:0] T1 = 7'b1111001;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one pair and follow it through to the output handshake.
  // early: out_ready is raised before out_valid.
  // hold: number of cycles out_ready stays low in HOLD, with in_valid pulses.
  task automatic xfer(input logic [6:0] tens, input logic [6:0] ones,
                      input logic [3:0] eb, input logic ee,
                      input bit early, input int hold);
    sb_t e;
    check("in_ready_idle", in_ready, 1);
    seg_tens  = tens;
    seg_ones  = ones;
    in_valid  = 1'b1;
    out_ready = early;
    sb.push_back('{bcd: eb, err: ee});
    @(posedge clk); #1;                       // transfer edge N
    in_valid = 1'b0;
    seg_tens = 7'($urandom);
    seg_ones = 7'($urandom);
    check("in_ready_busy", in_ready, 0);
    check("ov_capture", out_valid, 0);
    @(posedge clk); #1;                       // N+1
    check("ov_decode", out_valid, 0);
    @(posedge clk); #1;                       // N+2: HOLD entered
    check("ov_hold", out_valid, 1);
    if (sb.size() == 0) begin
      check("sb_nonempty", 0, 1);
    end else begin
      e = sb.pop_front();
      check("bcd", bcd, e.bcd);
      check("err", err, e.err);
      for (int i = 0; i < hold; i++) begin
        in_valid = i[0];
        seg_tens = T1;
        seg_ones = 7'b1000000;
        @(posedge clk); #1;
        check("hold_ov", out_valid, 1);
        check("hold_bcd", bcd, e.bcd);
        check("hold_err", err, e.err);
        check("hold_in_ready", in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;                     // handshake edge
      out_ready = 1'b0;
      if (e.err && exp_cnt != 255) exp_cnt++;
      check("ov_cleared", out_valid, 0);
      check("in_ready_back", in_ready, 1);
      check("err_cnt", err_cnt, exp_cnt);
      $display("xfer tens=%b ones=%b -> bcd=%0d err=%0d err_cnt=%0d",
               tens, ones, e.bcd, e.err, err_cnt);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    seg_ones  = 7'h00;
    seg_tens  = 7'h00;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_bcd", bcd, 0);
    check("rst_err", err, 0);
    check("rst_err_cnt", err_cnt, 0);
    rst_n = 1'b1;

    // Directed pairs
    xfer(T0, 7'b0010010, 4'd5,  1'b0, 1'b0, 0);
    xfer(T1, 7'b0110000, 4'd13, 1'b0, 1'b0, 0);
    xfer(T1, 7'b0000010, 4'd0,  1'b1, 1'b0, 0);   // 16 is out of range
`ifdef SEG_ALT5_EN
    xfer(T1, 7'b1001001, 4'd15, 1'b0, 1'b0, 0);
    xfer(T0, 7'b1001001, 4'd5,  1'b0, 1'b0, 0);
`else
    xfer(T1, 7'b1001001, 4'd0,  1'b1, 1'b0, 0);
    xfer(T0, 7'b1001001, 4'd0,  1'b1, 1'b0, 0);
`endif
    xfer(T0, 7'b1111001, 4'd1,  1'b0, 1'b1, 0);   // out_ready high early
    xfer(T1, 7'b1000000, 4'd10, 1'b0, 1'b0, 0);
    xfer(T0, 7'b0011000, 4'd9,  1'b0, 1'b0, 0);
    xfer(T1, 7'b0010010, 4'd15, 1'b0, 1'b0, 0);   // largest legal value
    xfer(T1, 7'b0011001, 4'd14, 1'b0, 1'b0, 0);
    xfer(T0, 7'b0000000, 4'd8,  1'b0, 1'b0, 0);
    xfer(T0, 7'b1111000, 4'd7,  1'b0, 1'b0, 0);
    xfer(7'b1111111, 7'b1000000, 4'd0, 1'b1, 1'b0, 0);  // bad tens
    xfer(T0, 7'b1111111, 4'd0,  1'b1, 1'b0, 0);   // bad ones

    // Long HOLD with ignored in_valid pulses
    xfer(T1, 7'b0100100, 4'd12, 1'b0, 1'b0, 10);
    repeat (4) begin
      @(posedge clk); #1;
      check("no_extra_output", out_valid, 0);
    end

    // Reset asserted during DECODE with an err pair in flight
    seg_tens = T0;
    seg_ones = 7'b1111111;
    in_valid = 1'b1;
    @(posedge clk); #1;                       // transfer -> CAPTURE
    in_valid = 1'b0;
    @(posedge clk); #1;                       // DECODE
    rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_err_cnt", err_cnt, exp_cnt);
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_hold_out_valid", out_valid, 0);
      check("rst_hold_err_cnt", err_cnt, exp_cnt);
    end
    $display("reset during DECODE: pending pair discarded, err_cnt=%0d", err_cnt);
    // Release mid-cycle. The first transfer happens on the first edge
    // that sees rst_n high.
    rst_n = 1'b1;
    xfer(T0, 7'b0110000, 4'd3, 1'b0, 1'b0, 0);

    // Saturation of err_cnt
    for (int i = 0; i < 260; i++) begin
      xfer(T0, 7'b1111111, 4'd0, 1'b1, 1'b0, 0);
    end
    check("err_cnt_sat", err_cnt, 255);
    check("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
